// File: rtl/dmem_resp_pkg.sv
// Shared constants, state encoding and the address-error helper for the
// data-memory responder that serves MEM-stage loads and stores.
package dmem_resp_pkg;

  // Responder FSM state encoding (2 bits).
  typedef enum logic [1:0] {
    DmemIdle = 2'd0,
    DmemWait = 2'd1,
    DmemResp = 2'd2
  } dmem_state_e;

  // Data bus width and the all-zero word driven when no load data is valid.
  localparam int          RegBusWidth = 32;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  // Byte-enable width; bit 3 selects bits 31:24 (big-endian lane order).
  localparam int DmemSelWidth = 4;

  // Error flag values reported alongside the acknowledge.
  localparam logic DmemErr = 1'b1;
  localparam logic DmemOk  = 1'b0;

  // An access is bad when it is not word aligned, or when any byte-address
  // bit above the RAM's word index is set. Out-of-range addresses are
  // rejected rather than folded onto a lower word, so they never alias.
  function automatic logic addr_is_bad(input logic [31:0] addr,
                                       input int unsigned addr_w);
    logic [31:0] upper;
    upper = addr >> (addr_w + 2);
    return ((addr[1:0] != 2'b00) || (upper != 32'h0)) ? DmemErr : DmemOk;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables. Writes and reads are both
// synchronous; the read register only updates when a read is requested, so
// the last loaded word stays put while stores or idle cycles go by.
module dmem_array
  import dmem_resp_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                    clk,
  input  logic [DmemSelWidth-1:0] be_i,
  input  logic                    re_i,
  input  logic [ADDR_W-1:0]       addr_i,
  input  logic [RegBusWidth-1:0]  wdata_i,
  output logic [RegBusWidth-1:0]  rdata_o
);

  localparam int Depth = 2 ** ADDR_W;

  logic [RegBusWidth-1:0] mem [Depth];
  logic [RegBusWidth-1:0] rdata_q;
  logic [RegBusWidth-1:0] rdata_d;

  // Byte-lane write: lane b covers bits 8*b+7 : 8*b, so be_i[3] hits 31:24.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DmemSelWidth; b++) begin
      if (be_i[b]) begin
        mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read data is captured only on a read request, otherwise held.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem[addr_i];
    end
  end

  // Synchronous read register (no reset: RAM contents are undefined anyway).
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder for the MIPS MEM stage. Accepts one load/store at a
// time in IDLE, waits a fixed number of cycles, performs the RAM access on
// the edge that enters RESP and then pulses ack for one cycle with the load
// data or an address error.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam logic [2:0] WaitLoad = WAIT_CYCLES[2:0];
  localparam logic       NoWait   = (WAIT_CYCLES == 0);

  dmem_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        wait_done;
  logic        go_resp;
  logic [31:0] acc_addr;
  logic        acc_we;
  logic [3:0]  acc_sel;
  logic [31:0] acc_wdata;
  logic        acc_err;
  logic [3:0]  ram_be;
  logic        ram_re;
  logic [31:0] ram_rdata;

  // Handshake and access-timing decode. With no wait states the access
  // happens on the acceptance edge itself, so the request is taken straight
  // from the inputs; otherwise the latched copy is used. Holding reset low
  // blocks any access so nothing is written while the block is in reset.
  always_comb begin
    accept    = (state_q == DmemIdle) && req_i;
    wait_done = (cnt_q <= 3'd1);
    go_resp   = rst && (((state_q == DmemWait) && wait_done) ||
                        (accept && NoWait));
    if (state_q == DmemIdle) begin
      acc_addr  = addr_i;
      acc_we    = we_i;
      acc_sel   = sel_i;
      acc_wdata = wdata_i;
    end else begin
      acc_addr  = addr_q;
      acc_we    = we_q;
      acc_sel   = sel_q;
      acc_wdata = wdata_q;
    end
    acc_err = addr_is_bad(acc_addr, ADDR_W);
    ram_be  = (go_resp && !acc_err && acc_we) ? acc_sel : 4'b0000;
    ram_re  = go_resp && !acc_err && !acc_we;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DmemIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; requests outside IDLE are ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DmemIdle: begin
        if (req_i) begin
          state_d = NoWait ? DmemResp : DmemWait;
        end
      end
      DmemWait: begin
        if (wait_done) begin
          state_d = DmemResp;
        end
      end
      DmemResp: state_d = DmemIdle;
      default:  state_d = DmemIdle;
    endcase
  end

  // Request latch, wait counter and error flag next values. The error flag
  // is only set for the single RESP cycle so it is naturally qualified.
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    if (accept) begin
      cnt_d   = WaitLoad;
      addr_d  = addr_i;
      we_d    = we_i;
      sel_d   = sel_i;
      wdata_d = wdata_i;
    end else if ((state_q == DmemWait) && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end
    err_d = go_resp ? acc_err : DmemOk;
  end

  // Datapath registers, cleared by reset so a dropped request leaves no trace.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 3'd0;
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      sel_q   <= 4'b0000;
      wdata_q <= ZeroWord;
      err_q   <= DmemOk;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  dmem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk    (clk),
    .be_i   (ram_be),
    .re_i   (ram_re),
    .addr_i (acc_addr[ADDR_W+1:2]),
    .wdata_i(acc_wdata),
    .rdata_o(ram_rdata)
  );

  // FSM outputs; load data is only exposed during an error-free load ack.
  always_comb begin
    ready_o = (state_q == DmemIdle);
    ack_o   = (state_q == DmemResp);
    err_o   = err_q;
    rdata_o = (ack_o && !we_q && !err_q) ? ram_rdata : ZeroWord;
  end

endmodule
